// File: rtl/umult_pkg.sv
// -----------------------------------------------------------------------------
// umult_pkg
// Shared definitions for the iterative unsigned multiplier:
//   - UMULT_DEFAULT_WIDTH : default operand width
//   - umult_state_e       : control FSM states (IDLE, RUN, DONE)
//   - umult_cnt_width()   : width of the step counter (clog2 of width+1)
// -----------------------------------------------------------------------------
package umult_pkg;

  localparam int UMULT_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } umult_state_e;

  function automatic int umult_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : umult_pkg

// File: rtl/u_multiplier_if.sv
// -----------------------------------------------------------------------------
// u_multiplier_if
// Start/done handshake and operand/result bus of the multiplier.
//   start : request pulse, operands sampled on the same edge
//   in1   : multiplicand (WIDTH bits, unsigned)
//   in2   : multiplier   (WIDTH bits, unsigned)
//   busy  : operation in progress
//   done  : one-cycle pulse when out becomes valid
//   out   : product (2*WIDTH+1 bits, top bit always 0)
// Modports: master (requester), slave (multiplier).
// -----------------------------------------------------------------------------
interface u_multiplier_if
  import umult_pkg::*;
#(
  parameter int WIDTH = UMULT_DEFAULT_WIDTH
) ();

  logic               start;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               busy;
  logic               done;
  logic [2*WIDTH:0]   out;

  modport master (output start, in1, in2, input busy, done, out);
  modport slave  (input start, in1, in2, output busy, done, out);

endinterface : u_multiplier_if

// File: rtl/umult_step.sv
// -----------------------------------------------------------------------------
// umult_step
// Combinational add-and-shift step of the shift-and-add multiplier.
// The accumulator holds {partial-sum upper part, remaining multiplier bits};
// the low bit(s) of the multiplier select the partial product that is added
// into the upper part before the whole pair shifts right.
// Configuration: UMULT_RADIX4_EN selects two multiplier bits per step
// (partial product 0/A/2A/3A, 3A supplied precomputed); otherwise one bit.
//   i_acc    : current accumulator
//   i_mcand  : multiplicand A
//   i_mcand3 : 3*A (radix-4 build only)
//   o_acc    : accumulator after this step
// -----------------------------------------------------------------------------
module umult_step
  import umult_pkg::*;
#(
  parameter int WIDTH = UMULT_DEFAULT_WIDTH
) (
`ifdef UMULT_RADIX4_EN
  input  logic [2*WIDTH+1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH+1:0]   i_mcand3,
  output logic [2*WIDTH+1:0] o_acc
`else
  input  logic [2*WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH:0]   o_acc
`endif
);

`ifdef UMULT_RADIX4_EN
  // Upper part is WIDTH+2 bits so hi + 3A never loses its carry.
  logic [WIDTH+1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH+1:0] w_pp;
  logic [WIDTH+1:0] w_sum;

  assign w_hi = i_acc[2*WIDTH+1:WIDTH];
  assign w_lo = i_acc[WIDTH-1:0];

  // Select partial product from two multiplier bits, add, shift right by two.
  always_comb begin
    w_pp = {(WIDTH+2){1'b0}};
    case (w_lo[1:0])
      2'b00:   w_pp = {(WIDTH+2){1'b0}};
      2'b01:   w_pp = {2'b00, i_mcand};
      2'b10:   w_pp = {1'b0, i_mcand, 1'b0};
      2'b11:   w_pp = i_mcand3;
      default: w_pp = {(WIDTH+2){1'b0}};
    endcase
    w_sum = w_hi + w_pp;
    o_acc = {2'b00, w_sum, w_lo[WIDTH-1:2]};
  end
`else
  // Upper part is WIDTH+1 bits so hi + A keeps its carry.
  logic [WIDTH:0]   w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH:0]   w_sum;

  assign w_hi = i_acc[2*WIDTH:WIDTH];
  assign w_lo = i_acc[WIDTH-1:0];

  // Conditionally add the multiplicand, then shift the pair right by one.
  always_comb begin
    w_sum = w_hi;
    if (w_lo[0]) begin
      w_sum = w_hi + {1'b0, i_mcand};
    end else begin
      w_sum = w_hi;
    end
    o_acc = {1'b0, w_sum, w_lo[WIDTH-1:1]};
  end
`endif

endmodule : umult_step

// File: rtl/u_multiplier.sv
// -----------------------------------------------------------------------------
// u_multiplier
// Iterative unsigned multiplier, one shift-and-add step per clock.
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   bus   : u_multiplier_if.slave (start/in1/in2 in, busy/done/out out)
// Latency: start sampled at edge N, done high after edge N+STEPS+1.
// Configuration: UMULT_RADIX4_EN consumes two multiplier bits per cycle
// (STEPS = WIDTH/2, WIDTH must be even); default build uses STEPS = WIDTH.
// -----------------------------------------------------------------------------
module u_multiplier
  import umult_pkg::*;
#(
  parameter int WIDTH = UMULT_DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  u_multiplier_if.slave  bus
);

`ifdef UMULT_RADIX4_EN
  localparam int ACC_W = 2*WIDTH + 2;
  localparam int STEPS = WIDTH / 2;
  if ((WIDTH % 2) != 0) begin : g_width_even_check
    $error("u_multiplier: radix-4 build requires an even WIDTH");
  end
`else
  localparam int ACC_W = 2*WIDTH + 1;
  localparam int STEPS = WIDTH;
`endif
  localparam int              CNT_W    = umult_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);

  umult_state_e     r_state;
  umult_state_e     w_state_next;
  logic             w_load;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;
  logic [WIDTH-1:0] r_mcand;
  logic [2*WIDTH:0] r_out;
  logic             r_busy;
  logic             r_done;
`ifdef UMULT_RADIX4_EN
  logic [WIDTH+1:0] r_mcand3;
`endif

  umult_step #(.WIDTH(WIDTH)) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
`ifdef UMULT_RADIX4_EN
    .i_mcand3 (r_mcand3),
`endif
    .o_acc    (w_acc_next)
  );

  // Next-state logic; start is only honoured when not busy.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == RUN);
      r_done  <= (w_state_next == DONE);
    end
  end

  // Datapath: operand capture, iteration, and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_acc    <= {ACC_W{1'b0}};
      r_mcand  <= {WIDTH{1'b0}};
      r_out    <= {(2*WIDTH+1){1'b0}};
`ifdef UMULT_RADIX4_EN
      r_mcand3 <= {(WIDTH+2){1'b0}};
`endif
    end else if (w_load) begin
      r_cnt    <= CNT_LOAD;
      r_acc    <= {{(ACC_W-WIDTH){1'b0}}, bus.in2};
      r_mcand  <= bus.in1;
`ifdef UMULT_RADIX4_EN
      r_mcand3 <= {2'b00, bus.in1} + {1'b0, bus.in1, 1'b0};
`endif
    end else if (r_state == RUN) begin
      if (r_cnt == {CNT_W{1'b0}}) begin
        // Product sits in the low 2*WIDTH bits once all steps are done.
        r_out <= {1'b0, r_acc[2*WIDTH-1:0]};
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_out <= r_out;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.out  = r_out;

endmodule : u_multiplier

// File: tb/tb_u_multiplier.sv
module tb_u_multiplier;
  import umult_pkg::*;

  localparam int W = 32;
`ifdef UMULT_RADIX4_EN
  localparam int LAT = W/2 + 1;
`else
  localparam int LAT = W + 1;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [2*W:0] prev_out;

  u_multiplier_if #(.WIDTH(W)) mul_if ();

  u_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mul_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W:0] ea;
    logic [2*W:0] eb;
    ea = {{(W+1){1'b0}}, a};
    eb = {{(W+1){1'b0}}, b};
    return ea * eb;
  endfunction

  // Called at a negedge: presents one start pulse and returns at the next negedge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    mul_if.start = 1'b1;
    mul_if.in1   = a;
    mul_if.in2   = b;
    @(negedge clk);
    mul_if.start = 1'b0;
    mul_if.in1   = $urandom;
    mul_if.in2   = $urandom;
  endtask

  // Counts edges since the start edge until done; also watches out stability.
  task automatic wait_done(input int k0, output int lat, output logic stable);
    lat    = k0;
    stable = 1'b1;
    while (mul_if.done !== 1'b1 && lat < LAT + 10) begin
      if (mul_if.out !== prev_out) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int   lat;
    logic stable;
    logic [2*W:0] exp;
    exp = ref_mul(a, b);
    launch(a, b);
    wait_done(0, lat, stable);
    check_eq({tag, "_lat"}, (2*W+1)'(lat), (2*W+1)'(LAT));
    check_eq({tag, "_out"}, mul_if.out, exp);
    check_eq({tag, "_stable"}, {{(2*W){1'b0}}, stable}, {{(2*W){1'b0}}, 1'b1});
    prev_out = exp;
  endtask

  initial begin
    int   lat;
    logic stable;
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_checks     = 0;
    n_fail       = 0;
    prev_out     = '0;
    rst_n        = 1'b0;
    mul_if.start = 1'b0;
    mul_if.in1   = '0;
    mul_if.in2   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {64'd0, mul_if.busy}, 65'd0);
    check_eq("rst_done", {64'd0, mul_if.done}, 65'd0);
    check_eq("rst_out", mul_if.out, 65'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic case, then one-cycle done pulse and held output.
    run_op("basic", 32'd3, 32'd5);
    check_eq("basic_busy_at_done", {64'd0, mul_if.busy}, 65'd0);
    @(negedge clk);
    check_eq("basic_done_pulse", {64'd0, mul_if.done}, 65'd0);
    check_eq("basic_busy_after", {64'd0, mul_if.busy}, 65'd0);
    check_eq("basic_out_hold", mul_if.out, 65'd15);
    @(negedge clk);

    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("max_literal", mul_if.out, 65'h0_FFFF_FFFE_0000_0001);
    @(negedge clk);
    run_op("zero", 32'd0, 32'h1234_5678);
    check_eq("zero_literal", mul_if.out, 65'd0);
    @(negedge clk);
    run_op("one", 32'hDEAD_BEEF, 32'd1);
    check_eq("one_literal", mul_if.out, 65'h0_0000_0000_DEAD_BEEF);
    @(negedge clk);

    // start while busy must be ignored.
    launch(32'd1000, 32'd77);
    repeat (4) @(negedge clk);
    mul_if.start = 1'b1;
    mul_if.in1   = 32'hABCD_0123;
    mul_if.in2   = 32'h0F0F_F0F0;
    @(negedge clk);
    mul_if.start = 1'b0;
    wait_done(5, lat, stable);
    check_eq("busy_start_lat", (2*W+1)'(lat), (2*W+1)'(LAT));
    check_eq("busy_start_out", mul_if.out, 65'd77000);
    prev_out = 65'd77000;
    @(negedge clk);
    check_eq("busy_start_no_restart", {64'd0, mul_if.busy}, 65'd0);

    // Back-to-back: start issued in the done cycle.
    run_op("b2b_a", 32'h8000_0001, 32'h0000_0003);
    run_op("b2b_b", 32'h1234_5678, 32'h9ABC_DEF0);

    // Reset during an operation: immediate clear, no done later.
    @(negedge clk);
    launch(32'h5555_5555, 32'hAAAA_AAAA);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {64'd0, mul_if.busy}, 65'd0);
    check_eq("midrst_done", {64'd0, mul_if.done}, 65'd0);
    check_eq("midrst_out", mul_if.out, 65'd0);
    prev_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (mul_if.done === 1'b1) stable = 1'b1;
    end
    check_eq("midrst_no_done", {64'd0, stable}, 65'd0);
    check_eq("midrst_out_after", mul_if.out, 65'd0);

    // Random operands with random idle gaps (0 = back-to-back).
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      if ((n % 50) == 0) a = 32'hFFFF_FFFF;
      if ((n % 70) == 1) b = 32'd0;
      run_op("rand", a, b);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(negedge clk);
        check_eq("rand_gap_hold", mul_if.out, prev_out);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_u_multiplier

// File: doc/u_multiplier.md
Name: u_multiplier

Overview:
- Iterative unsigned integer multiplier using shift-and-add, one partial-product step per clock.
- Multiplies two WIDTH-bit operands; result is 2*WIDTH+1 bits (65 bits at the default width).
- Sits in the arithmetic unit as a multi-cycle functional unit with a start/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; result width is 2*WIDTH+1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; operands sampled on the same edge.
- in1  in  WIDTH  multiplicand, unsigned.
- in2  in  WIDTH  multiplier, unsigned.
- busy  out  1  high while a multiplication is in progress.
- done  out  1  one-cycle pulse when out becomes valid.
- out  out  2*WIDTH+1  unsigned product; bit 2*WIDTH always 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, out=0, all internal registers cleared. Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1: capture in1/in2, clear accumulator, load counter=WIDTH, go to RUN, busy=1.
- RUN, each cycle: if the LSB of the multiplier register is 1, add the multiplicand into the upper half of the accumulator (WIDTH+1-bit add keeps the carry). Then shift the accumulator/multiplier pair right by 1 and decrement the counter.
- RUN with counter reaching 0: go to DONE, register the product into out, done=1 for exactly one cycle, busy=0.
- DONE: out holds. With no start, go to IDLE next cycle; out keeps its value until the next completion or reset.
- Latency: start sampled at edge N; done high after edge N+WIDTH+1 (33 cycles at default).
- start while busy=1: ignored; operands are not re-sampled.
- start in the same cycle as done (DONE state): accepted; new operation begins with no bubble.
- out changes only on the completion edge or reset; it never shows intermediate accumulator values.
- Arithmetic:
  - out[2*WIDTH-1:0] = in1*in2, exact modulo nothing; no overflow possible.
  - out[2*WIDTH] tied 0.
  - Zero and all-ones operands require no special casing.

Optional Feature:
- Macro UMULT_RADIX4_EN.
- Defined: two multiplier bits are consumed per cycle. Partial product is 0, A, 2A or 3A; 3A is precomputed at start. Shift by 2 per cycle; latency WIDTH/2+1 cycles (17 at default). WIDTH must be even, enforced by an elaboration-time check.
- Undefined: radix-2 behaviour above.
- Ports, handshake and results are identical in both builds.

Decomposition:
- Package umult_pkg holds:
  - default WIDTH constant;
  - state enum type (IDLE, RUN, DONE);
  - counter width function (clog2 of WIDTH+1).
- One sub-module, umult_step: combinational add-and-shift step taking the accumulator, multiplicand and multiplier bit(s) and returning the next accumulator. Its radix is selected by the same macro.
- The control FSM, counter and registers stay in u_multiplier.

Test Plan:
- Reset mid-run: assert rst_n=0 at cycle 10 of an operation -> busy=0, done=0, out=0 immediately; no done afterwards.
- Basic: in1=3, in2=5, start -> done after 33 cycles (17 with UMULT_RADIX4_EN), out=15, busy low afterwards.
- Max operands: in1=in2=0xFFFFFFFF -> out=0x0_FFFFFFFE_00000001, bit 64 = 0.
- Zero: in1=0, in2=0x12345678 -> out=0; then in1=0xDEADBEEF, in2=1 -> out=0xDEADBEEF.
- Handshake:
  - start pulsed while busy with new operands -> ignored; result matches the first operand pair.
  - start asserted in the done cycle -> back-to-back result correct.
- Random: 1000 $random operand pairs, each checked against a reference in1*in2; out stays stable between done pulses.
